// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM port controller and its response FIFO.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 8;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Synchronous first-word-visible FIFO with occupancy output; DEPTH must be a power of two.
module sram_ctrl_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              push_i,
    input  logic [WIDTH-1:0]                  data_i,
    input  logic                              pop_i,
    output logic                              valid_o,
    output logic [WIDTH-1:0]                  data_o,
    output logic [credit_width(DEPTH)-1:0]    count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = credit_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/sram_port_ctrl.sv
// Initiator for OpenRAM single-port macro port 0: arbitrates a write stream and a
// credit-guarded read-request stream onto registered csb0/web0/addr0/din0, and returns
// read data in order through a response FIFO.
// Optional build macro SRAM_PORT_CTRL_PERF_EN adds saturating perf counters.
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RSP_DEPTH  = 2,
    parameter int unsigned WR_PRIO    = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_req_addr,
    output logic                  rd_rsp_valid,
    input  logic                  rd_rsp_ready,
    output logic [DATA_WIDTH-1:0] rd_rsp_data,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  busy
`ifdef SRAM_PORT_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_rd_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    localparam int unsigned CW = credit_width(RSP_DEPTH);
    localparam int unsigned SW = CW + 3;

    op_e                   op_sel;
    logic                  rd_elig;
    logic                  credit_ok;
    logic                  rsp_pop;
    logic [SW-1:0]         outstanding;

    logic                  csb_q,  csb_d;
    logic                  web_q,  web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q,  din_d;
    logic [RD_LAT:0]       pipe_q, pipe_d;

    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [CW-1:0]         fifo_cnt;

    assign rsp_pop = fifo_valid && rd_rsp_ready;

    // Credit: reads in the capture pipe plus buffered responses, minus this cycle's pop.
    always_comb begin
        outstanding = '0;
        for (int unsigned i = 0; i <= RD_LAT; i++) begin
            outstanding = outstanding + SW'(pipe_q[i]);
        end
        outstanding = outstanding + SW'(fifo_cnt) - SW'(rsp_pop);
        credit_ok   = (outstanding < SW'(RSP_DEPTH));
    end

    // One operation per cycle; WR_PRIO decides a simultaneous request.
    always_comb begin
        op_sel       = OP_IDLE;
        rd_elig      = rd_req_valid && credit_ok;
        wr_ready     = !rst0 && !(rd_elig && (WR_PRIO == 0));
        rd_req_ready = !rst0 && credit_ok && !(wr_valid && (WR_PRIO != 0));
        if (!rst0) begin
            if (wr_valid && rd_elig) begin
                op_sel = (WR_PRIO != 0) ? OP_WR : OP_RD;
            end else if (wr_valid) begin
                op_sel = OP_WR;
            end else if (rd_elig) begin
                op_sel = OP_RD;
            end
        end
    end

    // Next port-register values and read-tracking shift.
    always_comb begin
        csb_d  = 1'b1;
        web_d  = 1'b1;
        addr_d = addr_q;
        din_d  = din_q;
        case (op_sel)
            OP_WR: begin
                csb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = wr_addr;
                din_d  = wr_data;
            end
            OP_RD: begin
                csb_d  = 1'b0;
                addr_d = rd_req_addr;
            end
            default: ;
        endcase
        pipe_d = {pipe_q[RD_LAT-1:0], (op_sel == OP_RD)};
    end

    // Registered SRAM port and in-flight read tracking; reset drops in-flight reads.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            csb_q  <= 1'b1;
            web_q  <= 1'b1;
            addr_q <= '0;
            din_q  <= '0;
            pipe_q <= '0;
        end else begin
            csb_q  <= csb_d;
            web_q  <= web_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            pipe_q <= pipe_d;
        end
    end

    // pipe_q[RD_LAT] marks the edge where dout0 holds the read's data.
    sram_ctrl_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk0),
        .rst_i   (rst0),
        .push_i  (pipe_q[RD_LAT]),
        .data_i  (dout0),
        .pop_i   (rsp_pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_data),
        .count_o (fifo_cnt)
    );

    assign csb0         = csb_q;
    assign web0         = web_q;
    assign addr0        = addr_q;
    assign din0         = din_q;
    assign rd_rsp_valid = fifo_valid;
    assign rd_rsp_data  = fifo_data;
    assign busy         = (|pipe_q) || fifo_valid;

`ifdef SRAM_PORT_CTRL_PERF_EN
    logic [31:0] perf_wr_q, perf_rd_q, perf_stall_q;

    // Saturating activity counters.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            perf_wr_q    <= '0;
            perf_rd_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (wr_valid && wr_ready && (perf_wr_q != '1)) begin
                perf_wr_q <= perf_wr_q + 1'b1;
            end
            if (rd_req_valid && rd_req_ready && (perf_rd_q != '1)) begin
                perf_rd_q <= perf_rd_q + 1'b1;
            end
            if (rd_req_valid && !rd_req_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_wr_cnt    = perf_wr_q;
    assign perf_rd_cnt    = perf_rd_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
